// File: rtl/snoopy_bus_controller_if.sv
// Bus bundle between the snoopy bus controller, the cache controllers and shared memory.
interface snoopy_bus_controller_if #(
  parameter int unsigned ADDRESS_WIDTH    = 8,
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned NUMBER_OF_CACHES = 4,
  parameter int unsigned COMMAND_WIDTH    = 2
);
  logic [NUMBER_OF_CACHES-1:0]               cpuRequest;
  logic [NUMBER_OF_CACHES*COMMAND_WIDTH-1:0] cpuCommandIn;
  logic [NUMBER_OF_CACHES*ADDRESS_WIDTH-1:0] cpuAddressIn;
  logic [NUMBER_OF_CACHES-1:0]               cpuGrant;
  logic [DATA_WIDTH-1:0]                     cpuDataOut;
  logic                                      cpuFunctionComplete;
  logic [COMMAND_WIDTH-1:0]                  snoopCommandOut;
  logic [ADDRESS_WIDTH-1:0]                  snoopAddressOut;
  logic [NUMBER_OF_CACHES-1:0]               snoopIsInvalidated;
  logic [ADDRESS_WIDTH-1:0]                  memoryAddress;
  logic                                      memoryReadEnabled;
  logic [DATA_WIDTH-1:0]                     memoryDataIn;
  logic                                      memoryFunctionComplete;

  modport master (
    input  cpuRequest, cpuCommandIn, cpuAddressIn, snoopIsInvalidated,
           memoryDataIn, memoryFunctionComplete,
    output cpuGrant, cpuDataOut, cpuFunctionComplete, snoopCommandOut,
           snoopAddressOut, memoryAddress, memoryReadEnabled
  );

  modport slave (
    output cpuRequest, cpuCommandIn, cpuAddressIn, snoopIsInvalidated,
           memoryDataIn, memoryFunctionComplete,
    input  cpuGrant, cpuDataOut, cpuFunctionComplete, snoopCommandOut,
           snoopAddressOut, memoryAddress, memoryReadEnabled
  );
endinterface

// File: rtl/snoopy_bus_controller.sv
// Round-robin bus arbiter for an invalidate-protocol snoopy cache system: grants one cache,
// broadcasts its command, collects snoop acks, performs the memory read and strobes completion.
module snoopy_bus_controller #(
  parameter int unsigned ADDRESS_WIDTH    = 8,
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned NUMBER_OF_CACHES = 4,
  parameter int unsigned COMMAND_WIDTH    = 2
) (
  input logic                    clock,
  input logic                    reset,
  snoopy_bus_controller_if.master bus
);
  localparam int unsigned N     = NUMBER_OF_CACHES;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [COMMAND_WIDTH-1:0] CMD_NONE       = COMMAND_WIDTH'(0);
  localparam logic [COMMAND_WIDTH-1:0] CMD_INVALIDATE = COMMAND_WIDTH'(3);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SNOOP  = 2'd1;
  localparam logic [1:0] MEMORY = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]               state_q, state_d;
  logic [IDX_W-1:0]         last_q, last_d, idx_q, idx_d;
  logic [COMMAND_WIDTH-1:0] cmd_q, cmd_d, snoop_cmd_q, snoop_cmd_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d, snoop_addr_q, snoop_addr_d, mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic [N-1:0]             grant_q, grant_d;
  logic                     complete_q, complete_d, mem_rd_q, mem_rd_d;

  logic [N-1:0]             eligible;
  logic [COMMAND_WIDTH-1:0] cmd_arr  [N];
  logic [ADDRESS_WIDTH-1:0] addr_arr [N];
  logic                     found;
  logic [IDX_W-1:0]         winner;
  logic                     acks_done;
  int unsigned              j;

  // Per-cache slices; a NONE command never makes a cache eligible.
  for (genvar i = 0; i < N; i++) begin : g_slice
    assign cmd_arr[i]  = bus.cpuCommandIn[i*COMMAND_WIDTH +: COMMAND_WIDTH];
    assign addr_arr[i] = bus.cpuAddressIn[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign eligible[i] = bus.cpuRequest[i] && (cmd_arr[i] != CMD_NONE);
  end

  // Round-robin scan starting just after the last winner.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    j      = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      j = (32'(last_q) + k) % N;
      if (!found && eligible[IDX_W'(j)]) begin
        found  = 1'b1;
        winner = IDX_W'(j);
      end
    end
  end

  // The winner's own ack bit is masked off.
  assign acks_done = ((bus.snoopIsInvalidated & ~grant_q) == ~grant_q);

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    idx_d        = idx_q;
    cmd_d        = cmd_q;
    addr_d       = addr_q;
    grant_d      = grant_q;
    data_d       = data_q;
    snoop_cmd_d  = CMD_NONE;
    snoop_addr_d = snoop_addr_q;
    mem_addr_d   = mem_addr_q;
    mem_rd_d     = 1'b0;
    complete_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          idx_d        = winner;
          cmd_d        = cmd_arr[winner];
          addr_d       = addr_arr[winner];
          grant_d      = N'(1) << winner;
          snoop_cmd_d  = cmd_arr[winner];
          snoop_addr_d = addr_arr[winner];
          state_d      = SNOOP;
        end
      end
      SNOOP: begin
        snoop_cmd_d = cmd_q;
        if (acks_done) begin
          snoop_cmd_d = CMD_NONE;
          if (cmd_q == CMD_INVALIDATE) begin
            complete_d = 1'b1;
            state_d    = DONE;
          end else begin
            mem_rd_d   = 1'b1;
            mem_addr_d = addr_q;
            state_d    = MEMORY;
          end
        end
      end
      MEMORY: begin
        mem_rd_d = 1'b1;
        if (bus.memoryFunctionComplete) begin
          mem_rd_d   = 1'b0;
          data_d     = bus.memoryDataIn;
          complete_d = 1'b1;
          state_d    = DONE;
        end
      end
      default: begin
        grant_d = '0;
        last_d  = idx_q;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_q       <= IDX_W'(N - 1);
      idx_q        <= '0;
      cmd_q        <= CMD_NONE;
      addr_q       <= '0;
      grant_q      <= '0;
      data_q       <= '0;
      snoop_cmd_q  <= CMD_NONE;
      snoop_addr_q <= '0;
      mem_addr_q   <= '0;
      mem_rd_q     <= 1'b0;
      complete_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      idx_q        <= idx_d;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      grant_q      <= grant_d;
      data_q       <= data_d;
      snoop_cmd_q  <= snoop_cmd_d;
      snoop_addr_q <= snoop_addr_d;
      mem_addr_q   <= mem_addr_d;
      mem_rd_q     <= mem_rd_d;
      complete_q   <= complete_d;
    end
  end

  assign bus.cpuGrant            = grant_q;
  assign bus.cpuDataOut          = data_q;
  assign bus.cpuFunctionComplete = complete_q;
  assign bus.snoopCommandOut     = snoop_cmd_q;
  assign bus.snoopAddressOut     = snoop_addr_q;
  assign bus.memoryAddress       = mem_addr_q;
  assign bus.memoryReadEnabled   = mem_rd_q;
endmodule

// File: doc/snoopy_bus_controller.md
Name: snoopy_bus_controller

Overview:
- Central bus controller for the invalidate-protocol snoopy cache system.
- Sits between the NUMBER_OF_CACHES cache controllers and shared memory.
- Arbitrates cache bus requests round-robin and broadcasts the winner's command and address to all other caches' snoop ports.
- Collects their isInvalidated acknowledgements, performs the memory read when the command needs data, and returns the data and a completion strobe to the winner.

Parameters:
- ADDRESS_WIDTH, 8, bus/memory address width.
- DATA_WIDTH, 8, memory data width.
- NUMBER_OF_CACHES, 4, number of cache ports (N).
- COMMAND_WIDTH, 2, command encoding width. Encodings: NONE=0, BUS_READ=1, BUS_READ_EXCLUSIVE=2, BUS_INVALIDATE=3.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- cpuRequest  input  N  per-cache bus request.
- cpuCommandIn  input  N*COMMAND_WIDTH  per-cache command; slice i belongs to cache i.
- cpuAddressIn  input  N*ADDRESS_WIDTH  per-cache address.
- cpuGrant  output  N  one-hot grant.
- cpuDataOut  output  DATA_WIDTH  data returned to the winner.
- cpuFunctionComplete  output  1  one-cycle completion strobe, qualified by cpuGrant.
- snoopCommandOut  output  COMMAND_WIDTH  command broadcast to snoopers; NONE when idle.
- snoopAddressOut  output  ADDRESS_WIDTH  broadcast address.
- snoopIsInvalidated  input  N  per-cache snoop acknowledgement.
- memoryAddress  output  ADDRESS_WIDTH  memory read address.
- memoryReadEnabled  output  1  memory read request.
- memoryDataIn  input  DATA_WIDTH  memory read data.
- memoryFunctionComplete  input  1  memory read done.

Behaviour:
- Reset:
  - All outputs 0; snoopCommandOut = NONE; state IDLE.
  - Round-robin pointer last = N-1, so cache 0 has highest priority first.
  - Reset mid-transaction aborts immediately with no completion strobe.
- FSM states: IDLE, SNOOP, MEMORY, DONE.
- IDLE:
  - Eligible caches are those with cpuRequest=1 and command != NONE.
  - Winner = first eligible index scanning last+1, last+2, … modulo N.
  - On the clock edge, register the winner's index, command and address; drive cpuGrant one-hot.
  - Next state: SNOOP. No eligible requester: stay IDLE.
  - Requests with command NONE are never granted.
- SNOOP:
  - snoopCommandOut and snoopAddressOut hold the latched values.
  - Wait until snoopIsInvalidated & ~cpuGrant equals ~cpuGrant, i.e. all non-winners have acked. The winner's own ack bit is ignored.
  - Next state: BUS_INVALIDATE goes to DONE; BUS_READ and BUS_READ_EXCLUSIVE go to MEMORY.
  - snoopCommandOut returns to NONE when leaving SNOOP.
- MEMORY:
  - memoryReadEnabled = 1; memoryAddress = latched address.
  - On memoryFunctionComplete = 1: latch memoryDataIn into cpuDataOut and go to DONE. memoryReadEnabled drops in the same transition.
  - Memory must not be re-requested in the cycle after completion.
- DONE:
  - cpuFunctionComplete = 1 for exactly one cycle while cpuGrant is still asserted.
  - Then update last = winner, clear cpuGrant, go to IDLE.
  - cpuDataOut holds its value until the next memory completion.
- Minimum latency from request to strobe:
  - BUS_INVALIDATE with immediate acks: 3 cycles.
  - BUS_READ with memory completing on the first MEMORY cycle: 4 cycles.
- Request handling:
  - Requesters hold their request until they see the strobe.
  - A request deasserting mid-transaction is ignored; the transaction completes.
  - A new request from the same cache is eligible from the IDLE cycle after DONE, at lowest priority.
- The controller never stalls on a cache that is not requesting. Acks are level-sensitive and sampled each cycle in SNOOP.
- Exactly one transaction is outstanding at a time; cpuGrant is never multi-hot.

Test Plan:
1. Reset, then cache 1 issues BUS_READ to address 0x3C; memory returns 0xA5 after 2 cycles.
   - cpuGrant=0010; snoop broadcast of command 1 at 0x3C.
   - memoryReadEnabled high until complete.
   - cpuDataOut=0xA5 with a single strobe.
2. Caches 0, 2 and 3 all request BUS_INVALIDATE simultaneously, held, with acks always high.
   - Grants in order 0001, 0100, 1000.
   - No memoryReadEnabled in any transaction.
3. Cache 2 issues BUS_READ_EXCLUSIVE; caches 0 and 3 ack immediately, cache 1 acks 5 cycles later.
   - Controller stays in SNOOP for 5 cycles; memory read starts only after cache 1 acks.
   - The winner's own ack bit tied low is ignored.
4. Cache 0 holds a request with command NONE while cache 3 requests BUS_READ.
   - Only cache 3 is granted; cache 0 is never granted.
5. Assert reset while in MEMORY with cpuGrant=0100.
   - All outputs go to 0 asynchronously; no strobe.
   - After release, cache 0 has first priority.
6. Cache 3 requests again immediately after its DONE while cache 0 is also requesting.
   - Cache 0 is granted next (wrap-around fairness).
